// File: rtl/bcd_scan_display.sv
// Multi-digit BCD up/down counter with prescaler, load and scanned 7-seg output.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 8,
    parameter int CNT_DIV  = 50,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   out,
    output logic                  wrap,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [WIDTH-1:0]      seg7
);

    localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       pre_q, pre_d;
    logic [SW-1:0]       scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic                wrap_q, wrap_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [WIDTH-1:0]    seg7_q, seg7_d;

    logic [4*DIGITS-1:0] step, clamped;
    logic                carry, tick;
    logic [3:0]          cur;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'h3F;
            4'd1:    decode = 8'h06;
            4'd2:    decode = 8'h5B;
            4'd3:    decode = 8'h4F;
            4'd4:    decode = 8'h66;
            4'd5:    decode = 8'h6D;
            4'd6:    decode = 8'h7D;
            4'd7:    decode = 8'h07;
            4'd8:    decode = 8'h7F;
            4'd9:    decode = 8'h6F;
            default: decode = 8'h00;
        endcase
    endfunction

    // Ripple carry/borrow chain; a carry out of the top digit is the wrap.
    always_comb begin
        logic [3:0] dg;
        step  = cnt_q;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dg = cnt_q[4*i +: 4];
            if (carry) begin
                if (up) begin
                    if (dg == 4'd9) dg = 4'd0;
                    else begin dg = dg + 4'd1; carry = 1'b0; end
                end else begin
                    if (dg == 4'd0) dg = 4'd9;
                    else begin dg = dg - 4'd1; carry = 1'b0; end
                end
            end
            step[4*i +: 4] = dg;
        end
    end

    always_comb begin
        clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
        end
    end

    assign tick = en && (pre_q == PW'(CNT_DIV - 1));

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = clamped;
            pre_d = '0;
        end else if (tick) begin
            cnt_d  = step;
            pre_d  = '0;
            wrap_d = carry;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    assign cur = cnt_q[4*int'(idx_q) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] shown;
    always_comb begin
        logic nz;
        nz    = 1'b0;
        shown = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz       = nz | (|cnt_q[4*i +: 4]);
            shown[i] = nz || (i == 0);
        end
    end
`endif

    always_comb begin
        dig_sel_d        = '0;
        dig_sel_d[idx_q] = 1'b1;
        seg7_d           = decode(cur);
`ifdef LEADING_ZERO_BLANK_EN
        if (!shown[idx_q]) seg7_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_q     <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            wrap_q    <= 1'b0;
            dig_sel_q <= '0;
            seg7_q    <= '0;
        end else begin
            pre_q     <= pre_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            dig_sel_q <= dig_sel_d;
            seg7_q    <= seg7_d;
        end
    end

    assign out     = cnt_q;
    assign wrap    = wrap_q;
    assign dig_sel = dig_sel_q;
    assign seg7    = seg7_q;

endmodule
